// File: rtl/reaction_ctrl_if.sv
// Button/indicator bundle for the reaction timer.
// The bench drives the buttons through master; the controller uses slave.
interface reaction_ctrl_if;
  logic        go_n;
  logic        react_n;
  logic        led_on;
  logic        start_n;
  logic [19:0] result_ms;
  logic        result_valid;
  logic        false_start;

  modport master (
    output go_n,
    output react_n,
    input  led_on,
    input  start_n,
    input  result_ms,
    input  result_valid,
    input  false_start
  );

  modport slave (
    input  go_n,
    input  react_n,
    output led_on,
    output start_n,
    output result_ms,
    output result_valid,
    output false_start
  );
endinterface

// File: rtl/reaction_ctrl.sv
// Reaction timer: random pre-stimulus delay, then times the
// player's button press in ms with a timeout and false-start detection.
module reaction_ctrl #(
  parameter int MS_DIV       = 50000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int RAND_BITS    = 11,
  parameter int TIMEOUT_MS   = 9999
) (
  input logic            clk,
  input logic            reset,
  reaction_ctrl_if.slave bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] DELAY = 3'd1;
  localparam logic [2:0] ARMED = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] FOUL  = 3'd4;

  localparam int PW =
    (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [PW-1:0] PMAX =
    PW'(MS_DIV - 1);
  localparam logic [19:0] MIN_D =
    20'(MIN_DELAY_MS);
  localparam logic [19:0] TMO =
    20'(TIMEOUT_MS);

  logic [2:0]    state;
  logic [15:0]   lfsr;
  logic          fb;
  logic [PW-1:0] presc;
  logic [19:0]   delay_cnt;
  logic [19:0]   ms_cnt;
  logic          go_s1, go_s2, go_q;
  logic          rc_s1, rc_s2, rc_q;
  logic          go_press;
  logic          react_press;
  logic          busy;
  logic          tick;
  logic          led_on;
  logic          start_n;
  logic [19:0]   result_ms;
  logic          result_valid;
  logic          false_start;

  assign fb = lfsr[15] ^ lfsr[13]
            ^ lfsr[12] ^ lfsr[10];

  assign go_press    = go_q & ~go_s2;
  assign react_press = rc_q & ~rc_s2;

  assign busy = (state == DELAY)
             || (state == ARMED);
  assign tick = busy && (presc == PMAX);

  assign bus.led_on       = led_on;
  assign bus.start_n      = start_n;
  assign bus.result_ms    = result_ms;
  assign bus.result_valid = result_valid;
  assign bus.false_start  = false_start;

  // Buttons are idle-high, so the sync chain resets to 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      go_s1 <= 1'b1;
      go_s2 <= 1'b1;
      go_q  <= 1'b1;
      rc_s1 <= 1'b1;
      rc_s2 <= 1'b1;
      rc_q  <= 1'b1;
    end else begin
      go_s1 <= bus.go_n;
      go_s2 <= go_s1;
      go_q  <= go_s2;
      rc_s1 <= bus.react_n;
      rc_s2 <= rc_s1;
      rc_q  <= rc_s2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      lfsr         <= 16'hACE1;
      presc        <= '0;
      delay_cnt    <= '0;
      ms_cnt       <= '0;
      led_on       <= 1'b0;
      start_n      <= 1'b1;
      result_ms    <= '0;
      result_valid <= 1'b0;
      false_start  <= 1'b0;
    end else begin
      lfsr    <= {lfsr[14:0], fb};
      start_n <= 1'b1;
      if (!busy || tick) begin
        presc <= '0;
      end else begin
        presc <= presc + 1'b1;
      end
      unique case (state)
        IDLE, DONE, FOUL: begin
          if (go_press) begin
            state        <= DELAY;
            delay_cnt    <= MIN_D
              + 20'(lfsr[RAND_BITS-1:0]);
            result_valid <= 1'b0;
            false_start  <= 1'b0;
            presc        <= '0;
          end
        end
        DELAY: begin
          if (react_press) begin
            state       <= FOUL;
            false_start <= 1'b1;
            presc       <= '0;
          end else if (tick) begin
            if (delay_cnt == 20'd1) begin
              state   <= ARMED;
              led_on  <= 1'b1;
              start_n <= 1'b0;
              ms_cnt  <= '0;
              presc   <= '0;
            end else begin
              delay_cnt <= delay_cnt - 20'd1;
            end
          end
        end
        ARMED: begin
          // React beats a simultaneous timeout tick
          if (react_press) begin
            state        <= DONE;
            result_ms    <= ms_cnt;
            result_valid <= 1'b1;
            led_on       <= 1'b0;
            start_n      <= 1'b0;
            presc        <= '0;
          end else if (tick) begin
            if (ms_cnt + 20'd1 == TMO) begin
              state        <= DONE;
              result_ms    <= TMO;
              result_valid <= 1'b1;
              led_on       <= 1'b0;
              start_n      <= 1'b0;
              presc        <= '0;
            end else begin
              ms_cnt <= ms_cnt + 20'd1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          led_on <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_ctrl.sv
// Bench for reaction_ctrl: table of rounds plus reset corner cases,
// with a result scoreboard and an independent LFSR model.
module tb_reaction_ctrl;

  localparam int MSD  = 4;
  localparam int MIND = 2;
  localparam int RB   = 2;
  localparam int TO   = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reaction_ctrl_if bus();

  reaction_ctrl #(
    .MS_DIV      (MSD),
    .MIN_DELAY_MS(MIND),
    .RAND_BITS   (RB),
    .TIMEOUT_MS  (TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [15:0] m;
  always @(posedge clk or posedge reset) begin
    if (reset) m <= 16'hACE1;
    else m <= {m[14:0],
               m[15] ^ m[13] ^ m[12] ^ m[10]};
  end

  typedef struct {
    logic        foul;
    logic [19:0] ms;
  } exp_t;

  // kind: 0 react after n ticks, 1 timeout,
  //       2 early foul, 3 foul on expiry tick
  typedef struct {
    int          kind;
    int          n;
    bit          go_arm;
    logic        foul;
    logic [19:0] ms;
  } vec_t;

  exp_t sbq[$];
  vec_t tab[7];
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  logic rv_q = 1'b0;
  logic fs_q = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d",
               nm, act, exp);
    end
  endtask

  task automatic sample();
    exp_t e;
    if (!bus.start_n) pulses++;
    if ((bus.result_valid && !rv_q) ||
        (bus.false_start && !fs_q)) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected got result want none");
      end else begin
        e = sbq.pop_front();
        chk("sb_foul", 32'(bus.false_start),
            32'(e.foul));
        if (!e.foul)
          chk("sb_ms", 32'(bus.result_ms),
              32'(e.ms));
      end
    end
    rv_q = bus.result_valid;
    fs_q = bus.false_start;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    sample();
  endtask

  task automatic go_press(output int d);
    @(negedge clk);
    bus.go_n = 1'b0;
    step();
    step();
    @(negedge clk);
    d = MIND + int'(m[1:0]);
    step();
    chk("entry_rv", 32'(bus.result_valid), 0);
    chk("entry_fs", 32'(bus.false_start), 0);
    chk("entry_led", 32'(bus.led_on), 0);
  endtask

  task automatic run_round(input vec_t v,
                           input string nm);
    int   d, a, re, dn, p0;
    exp_t e;
    logic led_e, st_e, rv_e, fs_e;
    e.foul = v.foul;
    e.ms   = v.ms;
    sbq.push_back(e);
    go_press(d);
    a = 4 * d;
    unique case (v.kind)
      0: begin re = a + 4 * v.n + 1; dn = re; end
      1: begin re = -100; dn = a + 4 * TO; end
      2: begin re = 3; dn = re; end
      default: begin re = a; dn = re; end
    endcase
    p0 = pulses;
    for (int c = 1; c <= dn + 3; c++) begin
      @(negedge clk);
      if (c == 1) bus.go_n = 1'b1;
      if (c == re - 2) bus.react_n = 1'b0;
      if (c == re + 1) bus.react_n = 1'b1;
      if (v.go_arm && c == a + 1) bus.go_n = 1'b0;
      if (v.go_arm && c == a + 3) bus.go_n = 1'b1;
      step();
      led_e = !v.foul && c >= a && c < dn;
      st_e  = v.foul || !(c == a || c == dn);
      rv_e  = !v.foul && c >= dn;
      fs_e  = v.foul && c >= dn;
      chk({nm, "_led"}, 32'(bus.led_on), 32'(led_e));
      chk({nm, "_start_n"}, 32'(bus.start_n), 32'(st_e));
      chk({nm, "_rv"}, 32'(bus.result_valid), 32'(rv_e));
      chk({nm, "_fs"}, 32'(bus.false_start), 32'(fs_e));
    end
    chk({nm, "_pulses"}, 32'(pulses - p0),
        v.foul ? 0 : 2);
    if (!v.foul)
      chk({nm, "_ms"}, 32'(bus.result_ms), 32'(v.ms));
  endtask

  task automatic reset_outputs(input string nm);
    chk({nm, "_led"}, 32'(bus.led_on), 0);
    chk({nm, "_start_n"}, 32'(bus.start_n), 1);
    chk({nm, "_ms"}, 32'(bus.result_ms), 0);
    chk({nm, "_rv"}, 32'(bus.result_valid), 0);
    chk({nm, "_fs"}, 32'(bus.false_start), 0);
  endtask

  initial begin
    int d, p0;
    tab[0] = '{0, 3, 1'b0, 1'b0, 20'd3};
    tab[1] = '{0, 0, 1'b0, 1'b0, 20'd0};
    tab[2] = '{1, 0, 1'b0, 1'b0, 20'd5};
    tab[3] = '{2, 0, 1'b0, 1'b1, 20'd0};
    tab[4] = '{3, 0, 1'b0, 1'b1, 20'd0};
    tab[5] = '{0, 1, 1'b1, 1'b0, 20'd1};
    tab[6] = '{0, 4, 1'b0, 1'b0, 20'd4};

    bus.go_n    = 1'b1;
    bus.react_n = 1'b1;
    reset       = 1'b1;
    #2;
    reset_outputs("rst");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) step();

    for (int i = 0; i < 7; i++) begin
      run_round(tab[i], $sformatf("v%0d", i));
      repeat (3) step();
    end

    // Abort a round while the LED is lit
    go_press(d);
    for (int c = 1; c <= 4 * d + 2; c++) begin
      @(negedge clk);
      if (c == 1) bus.go_n = 1'b1;
      step();
    end
    chk("mid_led", 32'(bus.led_on), 1);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    reset_outputs("mid_rst");
    rv_q = 1'b0;
    fs_q = 1'b0;
    p0   = pulses;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (6) step();
    chk("mid_pulses", 32'(pulses - p0), 0);
    chk("mid_led_after", 32'(bus.led_on), 0);
    run_round(tab[0], "post_rst");

    chk("sb_empty", 32'(sbq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
